// File: rtl/riscv_defs.sv
// Shared RISC-V definitions for the front end.
// Holds the opcodes the fetcher and decoder care about, the J/B immediate
// extraction helpers, the fetch FSM state type and the instruction-queue
// entry layout.
package riscv_defs;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } fetch_entry_t;

  // J-type immediate, sign-extended (bit 0 always zero)
  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  // B-type immediate, sign-extended (bit 0 always zero)
  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Instruction-side cache handshake.
//   i_waiting : fetch request (fetcher -> cache)
//   i_addr    : word-aligned fetch address (fetcher -> cache)
//   i_result  : fetched word (cache -> fetcher)
//   i_m_ready : i_result valid for i_addr (cache -> fetcher)
interface instruction_fetcher_if;
  logic        i_waiting;
  logic [31:0] i_addr;
  logic [31:0] i_result;
  logic        i_m_ready;

  modport master (output i_waiting, output i_addr, input i_result, input i_m_ready);
  modport slave  (input i_waiting, input i_addr, output i_result, output i_m_ready);
endinterface

// File: rtl/inst_queue.sv
// Parameterized FIFO of fetched instructions.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : global enable; low freezes pointers, count and storage
//   push/din   : write an entry (ignored when full)
//   pop        : drop the head (ignored when empty)
//   flush      : empty the queue; overrides push and pop
//   dout       : entry at the head pointer
//   full/empty/count : occupancy
module inst_queue
  import riscv_defs::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = en && !flush && push && !full;
  assign do_pop  = en && !flush && pop && !empty;
  assign dout    = mem[head];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (en && flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + AW'(1);
      if (do_pop)  head <= head + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Instruction fetch unit in front of the instruction cache.
// Holds the PC, issues one-word requests over the icache handshake,
// predicts the next PC statically (JAL taken, backward branch taken,
// everything else pc+4) and queues {inst, pc, pred_taken, pred_pc} for issue.
//   clk_in, rst_in      : clock, asynchronous active-low reset
//   rdy_in              : global enable; low freezes all state
//   RoB_clear/_jump_pc  : flush everything and restart at RoB_jump_pc
//   icache              : request/response handshake to the cache
//   inst_*              : FIFO head; popped when inst_valid && inst_ready
module instruction_fetcher
  import riscv_defs::*;
#(
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  RoB_clear,
  input  logic [31:0]           RoB_jump_pc,
  instruction_fetcher_if.master icache,
  output logic                  inst_valid,
  output logic [31:0]           inst,
  output logic [31:0]           inst_pc,
  output logic                  inst_pred_taken,
  output logic [31:0]           inst_pred_pc,
  input  logic                  inst_ready
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(QUEUE_DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   pc;
  logic          pred_taken;
  logic [31:0]   pred_pc;
  logic          accept;
  fetch_entry_t  q_din;
  fetch_entry_t  q_head;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;

  // Static prediction on the word being returned this cycle
  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = pc + 32'd4;
    case (icache.i_result[6:0])
      OP_JAL: begin
        pred_taken = 1'b1;
        pred_pc    = pc + imm_j(icache.i_result);
      end
      OP_BRANCH: begin
        if (icache.i_result[31]) begin
          pred_taken = 1'b1;
          pred_pc    = pc + imm_b(icache.i_result);
        end
      end
      OP_JALR: begin
        pred_taken = 1'b0;
        pred_pc    = pc + 32'd4;
      end
      default: ;
    endcase
  end

  // A returning word is dropped when it coincides with a flush
  assign accept = (state == ST_REQ) && icache.i_m_ready && !RoB_clear;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (q_count != CNT_FULL) state_nxt = ST_REQ;
      ST_REQ:  if (accept)              state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
    end else if (rdy_in) begin
      if (RoB_clear) begin
        state <= ST_IDLE;
        pc    <= RoB_jump_pc;
      end else begin
        state <= state_nxt;
        if (accept) pc <= pred_pc;
      end
    end
  end

  assign q_din = '{inst: icache.i_result, pc: pc, pred_taken: pred_taken, pred_pc: pred_pc};

  inst_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk_in),
    .rst_n (rst_in),
    .en    (rdy_in),
    .push  (accept && !q_full),
    .pop   (inst_ready),
    .flush (RoB_clear),
    .din   (q_din),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign icache.i_waiting = (state == ST_REQ);
  assign icache.i_addr    = pc;

  // Head fields read as zero while empty so no stale storage leaks out
  assign inst_valid      = !q_empty;
  assign inst            = q_empty ? '0 : q_head.inst;
  assign inst_pc         = q_empty ? '0 : q_head.pc;
  assign inst_pred_taken = q_empty ? 1'b0 : q_head.pred_taken;
  assign inst_pred_pc    = q_empty ? '0 : q_head.pred_pc;

endmodule

// File: tb/tb_instruction_fetcher.sv
module tb_instruction_fetcher;

  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        RoB_clear;
  logic [31:0] RoB_jump_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_pred_taken;
  logic [31:0] inst_pred_pc;
  logic        inst_ready;

  instruction_fetcher_if ic ();

  instruction_fetcher #(
    .QUEUE_DEPTH (16),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .RoB_clear       (RoB_clear),
    .RoB_jump_pc     (RoB_jump_pc),
    .icache          (ic.master),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_pred_taken (inst_pred_taken),
    .inst_pred_pc    (inst_pred_pc),
    .inst_ready      (inst_ready)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- cache memory and responder ----------------
  logic [31:0] cmem [int unsigned];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (cmem.exists(a)) return cmem[a];
    return 32'h00000013;
  endfunction

  // Answers each request 2 cycles after i_waiting rises, one-cycle ready pulse
  initial begin : cache
    int cnt;
    cnt = 0;
    ic.i_m_ready = 1'b0;
    ic.i_result  = '0;
    forever begin
      @(posedge clk_in);
      #1;
      if (!rst_in) begin
        ic.i_m_ready = 1'b0;
        cnt = 0;
      end else if (rdy_in) begin
        if (ic.i_m_ready) begin
          ic.i_m_ready = 1'b0;
          cnt = 0;
        end else if (ic.i_waiting) begin
          cnt++;
          if (cnt == 2) begin
            ic.i_m_ready = 1'b1;
            ic.i_result  = rd(ic.i_addr);
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
    bit          tk;
    logic [31:0] npc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;

  // Immediate rebuilt by weighting individual instruction fields
  function automatic void predict(input logic [31:0] w, input logic [31:0] pc,
                                  output bit tk, output logic [31:0] npc);
    int off;
    tk  = 1'b0;
    npc = pc + 32'd4;
    if ((w & 32'h7F) == 32'h6F) begin
      off = int'((w >> 21) & 32'h3FF) * 2 + int'((w >> 20) & 32'h1) * 2048 +
            int'((w >> 12) & 32'hFF) * 4096 - (w[31] ? (1 << 20) : 0);
      tk  = 1'b1;
      npc = pc + 32'(off);
    end else if ((w & 32'h7F) == 32'h63 && w[31]) begin
      off = int'((w >> 8) & 32'hF) * 2 + int'((w >> 25) & 32'h3F) * 32 +
            int'((w >> 7) & 32'h1) * 2048 - 4096;
      tk  = 1'b1;
      npc = pc + 32'(off);
    end
  endfunction

  initial begin : compare
    bit          acc_last;
    bit          tk;
    bit          do_pop;
    logic [31:0] npc;
    acc_last = 1'b0;
    mpc = RST_PC;
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        mq.delete();
        mpc = RST_PC;
        acc_last = 1'b0;
        chk("m_rst_valid", inst_valid, 1'b0);
        chk("m_rst_wait", ic.i_waiting, 1'b0);
        chk("m_rst_addr", ic.i_addr, RST_PC);
      end else begin
        chk("m_valid", inst_valid, mq.size() != 0);
        if (mq.size() != 0) begin
          chk("m_inst", inst, mq[0].w);
          chk("m_pc", inst_pc, mq[0].pc);
          chk("m_taken", inst_pred_taken, mq[0].tk);
          chk("m_pred_pc", inst_pred_pc, mq[0].npc);
        end
        if (ic.i_waiting) chk("m_addr", ic.i_addr, mpc);
        if (mq.size() == 16) chk("m_full_noreq", ic.i_waiting, 1'b0);
        if (acc_last) chk("m_gap_after_accept", ic.i_waiting, 1'b0);
        acc_last = 1'b0;
        if (rdy_in) begin
          if (RoB_clear) begin
            mq.delete();
            mpc = RoB_jump_pc;
          end else begin
            do_pop = inst_ready && mq.size() != 0;
            if (ic.i_waiting && ic.i_m_ready) begin
              predict(ic.i_result, mpc, tk, npc);
              mq.push_back('{w: ic.i_result, pc: mpc, tk: tk, npc: npc});
              mpc = npc;
              acc_last = 1'b1;
            end
            if (do_pop) void'(mq.pop_front());
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic pop1();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic pulse_clear(input logic [31:0] target);
    RoB_clear   = 1'b1;
    RoB_jump_pc = target;
    tick();
    RoB_clear   = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 100 && !inst_valid; i++) tick();
    chk(name, inst_valid, 1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    int          n;
    logic [31:0] held;
    rst_in      = 1'b0;
    rdy_in      = 1'b1;
    RoB_clear   = 1'b0;
    RoB_jump_pc = '0;
    inst_ready  = 1'b0;
    cmem[32'h10] = 32'h0100006F;

    // Reset and first request
    repeat (3) begin
      tick();
      chk("rst_valid", inst_valid, 1'b0);
      chk("rst_wait", ic.i_waiting, 1'b0);
    end
    rst_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (ic.i_waiting) break;
    end
    chk("rst_first_req", ic.i_waiting, 1'b1);
    chk("rst_first_addr", ic.i_addr, 32'h0);

    // Sequential NOPs
    for (int i = 0; i < 100 && mq.size() < 3; i++) tick();
    chk("seq0_inst", inst, 32'h00000013);
    chk("seq0_pc", inst_pc, 32'h0);
    chk("seq0_taken", inst_pred_taken, 1'b0);
    chk("seq0_pred", inst_pred_pc, 32'h4);
    pop1();
    chk("seq1_pc", inst_pc, 32'h4);
    chk("seq1_pred", inst_pred_pc, 32'h8);
    pop1();
    chk("seq2_pc", inst_pc, 32'h8);
    chk("seq2_pred", inst_pred_pc, 32'hC);

    // JAL at 0x10
    for (int i = 0; i < 60; i++) begin
      if (inst_valid && inst_pc == 32'h10) break;
      if (inst_valid) pop1();
      else tick();
    end
    chk("jal_pc", inst_pc, 32'h10);
    chk("jal_inst", inst, 32'h0100006F);
    chk("jal_taken", inst_pred_taken, 1'b1);
    chk("jal_pred", inst_pred_pc, 32'h20);
    pop1();
    wait_valid("jal_next_valid");
    chk("jal_next_pc", inst_pc, 32'h20);

    // Fill to 16, then one pop allows exactly one refill
    for (int i = 0; i < 300 && mq.size() < 16; i++) tick();
    chk("full_reached", mq.size(), 16);
    repeat (8) begin
      tick();
      chk("full_idle", ic.i_waiting, 1'b0);
      chk("full_valid", inst_valid, 1'b1);
    end
    pop1();
    n = 0;
    repeat (20) begin
      if (ic.i_waiting && ic.i_m_ready) n++;
      tick();
    end
    chk("full_refetch_count", n, 1);
    chk("full_again_idle", ic.i_waiting, 1'b0);

    // Backward branch
    cmem[32'h40] = 32'hFE000EE3;
    pulse_clear(32'h40);
    wait_valid("bbr_valid");
    chk("bbr_pc", inst_pc, 32'h40);
    chk("bbr_taken", inst_pred_taken, 1'b1);
    chk("bbr_pred", inst_pred_pc, 32'h3C);
    pop1();
    wait_valid("bbr_next_valid");
    chk("bbr_next_pc", inst_pc, 32'h3C);

    // Forward branch
    cmem[32'h40] = 32'h00000463;
    pulse_clear(32'h40);
    wait_valid("fbr_valid");
    chk("fbr_pc", inst_pc, 32'h40);
    chk("fbr_taken", inst_pred_taken, 1'b0);
    chk("fbr_pred", inst_pred_pc, 32'h44);

    // rdy_in low freezes an outstanding request
    for (int i = 0; i < 20 && !ic.i_waiting; i++) tick();
    held = mpc;
    rdy_in = 1'b0;
    repeat (4) begin
      tick();
      chk("frz_wait", ic.i_waiting, 1'b1);
      chk("frz_addr", ic.i_addr, held);
    end
    rdy_in = 1'b1;

    // Flush while a word is returning with 5 entries queued
    pulse_clear(32'h80);
    for (int i = 0; i < 100 && !(mq.size() == 5 && ic.i_m_ready); i++) tick();
    chk("flush_setup", mq.size(), 5);
    RoB_clear   = 1'b1;
    RoB_jump_pc = 32'h100;
    tick();
    RoB_clear = 1'b0;
    chk("flush_valid", inst_valid, 1'b0);
    chk("flush_wait0", ic.i_waiting, 1'b0);
    tick();
    chk("flush_wait1", ic.i_waiting, 1'b1);
    chk("flush_addr", ic.i_addr, 32'h100);
    wait_valid("flush_refill_valid");
    chk("flush_refill_pc", inst_pc, 32'h100);

    // Asynchronous reset in the middle of a request
    for (int i = 0; i < 20 && !ic.i_waiting; i++) tick();
    rst_in = 1'b0;
    #1;
    chk("arst_wait", ic.i_waiting, 1'b0);
    chk("arst_addr", ic.i_addr, RST_PC);
    chk("arst_valid", inst_valid, 1'b0);
    tick();
    tick();
    rst_in = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetcher.md
# instruction_fetcher

Instruction fetch unit directly upstream of the instruction side of the cache. It holds the PC and issues one-word fetch requests over the `i_waiting`/`i_addr`/`i_m_ready` handshake. It applies static next-PC prediction to each returned word and buffers fetched instructions in a FIFO that feeds the decoder/issue stage. On a RoB flush it discards all in-flight and queued work and restarts at the redirect PC.

## Interface
- `QUEUE_DEPTH`, 16: instruction FIFO entries; power of two, ≥2
- `RESET_PC`, 32'h0: PC loaded on reset
- `clk_in` in 1: single system clock; all state on rising edge
- `rst_in` in 1: reset; asynchronous, active-low
- `rdy_in` in 1: global enable; low freezes all state, outputs hold
- `RoB_clear` in 1: flush/redirect request
- `RoB_jump_pc` in 32: redirect target, sampled when `RoB_clear` is high
- `i_waiting` out 1: fetch request to cache
- `i_addr` out 32: fetch address; word aligned
- `i_result` in 32: fetched word, valid when `i_m_ready` is high
- `i_m_ready` in 1: cache returns word for `i_addr`
- `inst_valid` out 1: FIFO head valid
- `inst` out 32: head instruction
- `inst_pc` out 32: head PC
- `inst_pred_taken` out 1: head predicted taken
- `inst_pred_pc` out 32: head predicted next PC
- `inst_ready` in 1: consumer pops head when `inst_valid` is also high

## Operation
- **Reset:** `pc`=`RESET_PC`; FIFO empty (head=tail=count=0); state IDLE. All outputs are 0 except `i_addr`, which is `RESET_PC`.
- **FSM states**
  - IDLE: if count < `QUEUE_DEPTH`, go to REQ next cycle.
  - REQ: `i_waiting`=1 and `i_addr`=`pc`, both held stable until accept. Accept occurs in the cycle `i_m_ready`=1. On accept: write entry, set `pc` to predicted next PC, go to IDLE. The guaranteed IDLE cycle between accepts prevents a stale `i_m_ready` being taken against the new address.
  - In IDLE, `i_waiting`=0.
- **Prediction** (combinational on `i_result`; all immediates sign-extended, all arithmetic modulo 2^32):
  - opcode 7'b1101111 (JAL): taken; target `pc` + J-imm.
  - opcode 7'b1100011 (branch): taken iff imm[12]=1 (backward); target `pc` + B-imm, else `pc`+4.
  - All others, JALR included: not taken; next PC `pc`+4.
- **FIFO entry:** {inst, pc, pred_taken, pred_pc}. Head outputs come from storage at the head pointer and are valid when count ≠ 0. Head and tail wrap modulo `QUEUE_DEPTH`.
- **Simultaneous push and pop:** count unchanged, both pointers advance. Full with a pop in the same cycle does not allow a push that cycle, because REQ is never entered when full.
- **`RoB_clear` (takes priority over everything, when `rdy_in`=1):**
  - `pc`=`RoB_jump_pc`; FIFO emptied; state IDLE.
  - A word returned that same cycle is dropped; a pop that same cycle is ignored.
  - `inst_valid`=0 from the next cycle.
- **`rdy_in`=0:** no push, pop, PC or state change; `i_waiting` and `i_addr` hold.
- **Asynchronous reset mid-request:** state returns to the reset values immediately; no partial entry is written.

## Timing
- `i_waiting` rises 1 cycle after entering IDLE with space available.
- A word accepted on cycle N is visible at the head on N+1 if the FIFO was empty; there is no bypass.
- Cache hit (current cache behaviour): `i_m_ready` arrives 2 cycles after `i_waiting` rises, so steady-state throughput is 1 instruction per 3 cycles.
- The fetcher is latency-agnostic and waits indefinitely in REQ.
- Redirect: `i_waiting` for `RoB_jump_pc` rises 2 cycles after the `RoB_clear` cycle.

## Structure
- Shared package (`riscv_defs`) holds opcode constants (`OP_JAL`, `OP_BRANCH`, `OP_JALR`) and the J/B immediate-extraction functions, which the decoder also uses.
- One sub-module: `inst_queue`, a parameterized FIFO with push, pop, flush, full/empty, count and head read port.
- The FSM and predictor stay in `instruction_fetcher`.

## Test plan
- **Reset:** `rst_in`=0, then released → within 2 cycles `i_waiting`=1, `i_addr`=0; `inst_valid`=0 throughout reset.
- **Sequential fetch:** cache returns 32'h00000013 (NOP) for addresses 0, 4, 8 → head entries have pc 0, 4, 8, `inst_pred_taken`=0, `inst_pred_pc`=pc+4.
- **JAL:** at 0x10, return 32'h0100006F (jal x0, +16) → entry `pred_taken`=1, `pred_pc`=0x20; next `i_addr`=0x20.
- **Backward branch:** at 0x40, return 32'hFE000EE3 (beq x0,x0,-4) → `pred_pc`=0x3C. The forward branch 32'h00000463 at 0x40 → `pred_pc`=0x44.
- **Full:** hold `inst_ready`=0 until 16 entries are queued → `i_waiting` stays 0. Pop one → exactly one more fetch, then FIFO full again.
- **Flush:** with 5 entries queued and a request outstanding, pulse `RoB_clear` with `RoB_jump_pc`=0x100 while `i_m_ready`=1 → word dropped, `inst_valid`=0 next cycle, then `i_addr`=0x100.
